// File: rtl/gate_cmd_tx_pkg.sv
// Shared definitions for the gate-command link: field widths, FSM state codes
// and the ECC equations. The receiving modules decode with the same gate_ecc().
package gate_cmd_tx_pkg;

    localparam int GATE_DATA_W  = 5;
    localparam int GATE_ECC_W   = 3;
    localparam int GATE_FRAME_W = GATE_DATA_W + GATE_ECC_W;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GUARD     = 3'd4;
    localparam logic [2:0] ST_SHOOT     = 3'd5;

    // c[0] = d0^d1^d3^d4, c[1] = d0^d2^d3, c[2] = d1^d2^d3^d4
    function automatic logic [GATE_ECC_W-1:0] gate_ecc(input logic [GATE_DATA_W-1:0] d);
        logic [GATE_ECC_W-1:0] c;
        c[0] = d[0] ^ d[1] ^ d[3] ^ d[4];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[1] ^ d[2] ^ d[3] ^ d[4];
        return c;
    endfunction

    function automatic int gate_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gate_cmd_tx_ecc_enc.sv
// Combinational frame builder: gate code in the top five bits, ECC below.
module gate_ecc_enc
    import gate_cmd_tx_pkg::*;
(
    input  logic [GATE_DATA_W-1:0]  data_i,
    output logic [GATE_FRAME_W-1:0] frame_o
);

    assign frame_o = {data_i, gate_ecc(data_i)};

endmodule

// File: rtl/gate_cmd_tx.sv
// Gate-command transmitter: takes a 5-bit gate code, hands the ECC-protected
// byte to uart_tx, waits for the frame to finish plus a decode guard time,
// then pulses the common shoot strobe so all modules latch together.
module gate_cmd_tx
    import gate_cmd_tx_pkg::*;
#(
    parameter int GUARD_CYCLES  = 48,
    parameter int SHOOT_CYCLES  = 24,
    parameter int START_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    input  logic [GATE_DATA_W-1:0]  cmd_code,
    output logic                    cmd_ready,
    output logic [GATE_FRAME_W-1:0] data_to_tx,
    output logic                    start_tx,
    input  logic                    tx_busy,
    output logic                    shoot,
    output logic                    busy,
    output logic                    tx_err,
    output logic [15:0]             frames_sent
);

    localparam int CNT_W = $clog2(gate_max3(GUARD_CYCLES, SHOOT_CYCLES, START_TIMEOUT)) + 1;
    // GUARD holds GUARD_CYCLES-1 cycles so shoot rises GUARD_CYCLES cycles after
    // the first low tx_busy sample; 0 and 1 both skip GUARD entirely.
    localparam int GUARD_LAST = (GUARD_CYCLES >= 2) ? GUARD_CYCLES - 2 : 0;

    logic [2:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [GATE_FRAME_W-1:0] data_q, data_d;
    logic [15:0]             frames_q, frames_d;
    logic                    tx_err_q, tx_err_d;
    logic [GATE_FRAME_W-1:0] frame;

    gate_ecc_enc u_enc (
        .data_i  (cmd_code),
        .frame_o (frame)
    );

    // Next-state logic; one counter is shared by timeout, guard and shoot width
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        frames_d = frames_q;
        tx_err_d = 1'b0;
        cnt_inc  = cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    data_d  = frame;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // counter holds cycles elapsed since the start_tx cycle
                cnt_d   = CNT_W'(1);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_inc >= CNT_W'(START_TIMEOUT)) begin
                    tx_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = (GUARD_CYCLES <= 1) ? ST_SHOOT : ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (cnt_q == CNT_W'(GUARD_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_SHOOT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SHOOT: begin
                if (cnt_q == CNT_W'(SHOOT_CYCLES - 1)) begin
                    cnt_d    = '0;
                    frames_d = frames_q + 16'd1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset truncates any transfer or shoot in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            frames_q <= '0;
            tx_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            frames_q <= frames_d;
            tx_err_q <= tx_err_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE) && !reset;
    assign start_tx    = (state_q == ST_LOAD);
    assign shoot       = (state_q == ST_SHOOT);
    assign busy        = (state_q != ST_IDLE);
    assign tx_err      = tx_err_q;
    assign data_to_tx  = data_q;
    assign frames_sent = frames_q;

endmodule
